// File: rtl/param_map_pkg.sv
// Parameter-BRAM layout shared by the arbiter and its requesters.
package param_map_pkg;

  localparam int PARAM_WORDS_PER_SUBSET = 5;
  localparam int PARAM_CX_OFFSET        = 3;
  localparam int PARAM_CY_OFFSET        = 4;
  localparam int PARAM_BYTES_PER_WORD   = 4;

  // Word index of field 'off' in subset n; record 0 is a header, so subsets start at word 5.
  function automatic logic [31:0] subset_word(input logic [31:0] n, input logic [31:0] off);
    return (n + 32'd1) * 32'(PARAM_WORDS_PER_SUBSET) + off;
  endfunction

endpackage

// File: rtl/param_read_arbiter_if.sv
// Requester-side handshake and BRAM read-port signals of the parameter arbiter.
interface param_read_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_word;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      param_ea;
  logic [3:0]                param_wea;
  logic [ADDR_W-1:0]         param_addr;
  logic [DATA_W-1:0]         param_dout;

  // Arbiter view.
  modport slave (
    input  req_valid, req_word, param_dout,
    output req_ready, rsp_valid, rsp_data, param_ea, param_wea, param_addr
  );

  // Requesters plus BRAM view.
  modport master (
    output req_valid, req_word, param_dout,
    input  req_ready, rsp_valid, rsp_data, param_ea, param_wea, param_addr
  );
endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request bit at or above ptr, wrapping at NUM_REQ.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  int              pos;
  logic [ID_W-1:0] idx;

  // Scan NUM_REQ positions from ptr; explicit wrap keeps non-power-of-2 counts correct.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    pos       = 0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = ID_W'(pos);
      if (!grant_any && req[idx]) begin
        grant_any     = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/param_read_arbiter.sv
// Round-robin arbiter sharing the parameter BRAM read port, with id-tagged response routing.
module param_read_arbiter
  import param_map_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 3
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 params_ready,
  output logic                 busy,
  param_read_arbiter_if.slave  bus
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]  req_eligible;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_any;
  logic [ADDR_W-3:0]   grant_word_lo;

  logic                param_ea_q, param_ea_d;
  logic [ADDR_W-1:0]   param_addr_q, param_addr_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [RD_LATENCY-1:0]           tag_vld_q, tag_vld_d;
  logic [RD_LATENCY-1:0][ID_W-1:0] tag_id_q, tag_id_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

  // Nothing is eligible until the BRAM has been loaded.
  assign req_eligible = bus.req_valid & {NUM_REQ{params_ready}};

  rr_priority_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req       (req_eligible),
    .ptr       (rr_ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Top two index bits fall off when the word index is scaled to bytes.
  assign grant_word_lo = bus.req_word[grant_idx*ADDR_W +: ADDR_W-2];

  // Next-state: address, priority pointer, tag pipeline and response register.
  always_comb begin
    param_ea_d   = params_ready;
    param_addr_d = param_addr_q;
    rr_ptr_d     = rr_ptr_q;
    if (grant_any) begin
      param_addr_d = {grant_word_lo, 2'b00};
      rr_ptr_d     = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = grant_any;
    tag_id_d[0]  = grant_idx;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_vld_q[RD_LATENCY-1]) begin
      rsp_valid_d[tag_id_q[RD_LATENCY-1]] = 1'b1;
      rsp_data_d                          = bus.param_dout;
    end
  end

  // State registers; reset discards every in-flight read.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      param_ea_q   <= 1'b0;
      param_addr_q <= '0;
      rr_ptr_q     <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
    end else begin
      param_ea_q   <= param_ea_d;
      param_addr_q <= param_addr_d;
      rr_ptr_q     <= rr_ptr_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign bus.req_ready  = grant_oh;
  assign bus.param_ea   = param_ea_q;
  assign bus.param_wea  = 4'b0000;
  assign bus.param_addr = param_addr_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign busy           = |tag_vld_q;

endmodule

// File: tb/tb_param_read_arbiter.sv
// Directed bench for param_read_arbiter with a response scoreboard and a latency-3 BRAM model.
module tb_param_read_arbiter;
  import param_map_pkg::*;

  localparam int NR  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  logic resetn;
  logic params_ready;
  logic busy;

  exp_t        sb[$];
  int          checks    = 0;
  int          failures  = 0;
  int          cyc       = 0;
  int          rsp_count = 0;
  int          rsp_mark  = 0;
  logic        started   = 1'b0;
  logic [31:0] word_v [NR];
  logic [31:0] a_p1, a_p2;

  param_read_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  param_read_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .params_ready (params_ready),
    .busy         (busy),
    .bus          (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] bram_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  always_comb begin
    bus.req_word = '0;
    for (int i = 0; i < NR; i++) bus.req_word[i*AW +: AW] = word_v[i];
  end

  // BRAM: address registered at edge 0 is sampled by the arbiter at edge LAT.
  always @(posedge clock) begin
    a_p1 <= bus.param_addr;
    a_p2 <= a_p1;
  end
  assign bus.param_dout = bram_word(a_p2);

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response scoreboard: every rsp_valid pulse must match the oldest outstanding grant.
  always @(negedge clock) begin
    if (started && resetn) begin
      if (bus.rsp_valid !== '0) begin
        rsp_count++;
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_id", 32'(bus.rsp_valid), 32'd1 << e.id);
          chk("rsp_data", bus.rsp_data, e.data);
          chk("rsp_latency", 32'(cyc - e.cyc), 32'(LAT + 1));
        end
      end else if (sb.size() != 0 && (cyc - sb[0].cyc) > LAT + 1) begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_missing", 32'(bus.rsp_valid), 32'd1 << e.id);
      end
    end
  end

  // Inputs are already set at this negedge; check the grant and book its response.
  task automatic step(input logic [NR-1:0] exp_rdy, input string tag);
    exp_t e;
    #1;
    chk(tag, 32'(bus.req_ready), 32'(exp_rdy));
    if (exp_rdy != '0) begin
      e.id = 0;
      for (int i = 0; i < NR; i++) if (exp_rdy[i]) e.id = i;
      e.data = bram_word({word_v[e.id][29:0], 2'b00});
      e.cyc  = cyc;
      sb.push_back(e);
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    sb.delete();
    #1;
    chk("rst_param_ea", 32'(bus.param_ea), 32'd0);
    chk("rst_param_wea", 32'(bus.param_wea), 32'd0);
    chk("rst_param_addr", bus.param_addr, 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    resetn        = 1'b1;
    params_ready  = 1'b0;
    bus.req_valid = '0;
    for (int i = 0; i < NR; i++) word_v[i] = subset_word(32'(i), PARAM_CX_OFFSET);
    @(negedge clock);
    do_reset();
    started = 1'b1;

    // Single read: subset 0 cx is word 8, byte address 32.
    params_ready  = 1'b1;
    word_v[0]     = subset_word(0, PARAM_CX_OFFSET);
    bus.req_valid = 4'b0001;
    step(4'b0001, "single_grant");
    bus.req_valid = '0;
    #1;
    chk("single_addr", bus.param_addr, 32'd32);
    chk("single_ea", 32'(bus.param_ea), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_wea", 32'(bus.param_wea), 32'd0);
    drain("single_drain");

    // Round robin with all requesters valid from pointer 0.
    do_reset();
    params_ready = 1'b1;
    for (int i = 0; i < NR; i++) word_v[i] = subset_word(32'(i + 2), PARAM_CY_OFFSET);
    bus.req_valid = 4'b1111;
    step(4'b0001, "rr_g0");
    step(4'b0010, "rr_g1");
    step(4'b0100, "rr_g2");
    step(4'b1000, "rr_g3");
    step(4'b0001, "rr_g4");
    step(4'b0010, "rr_g5");
    bus.req_valid = '0;
    drain("rr_drain");

    // Gating: nothing granted while params_ready is low.
    do_reset();
    params_ready  = 1'b0;
    word_v[2]     = subset_word(7, PARAM_CX_OFFSET);
    bus.req_valid = 4'b0100;
    for (int i = 0; i < 10; i++) step(4'b0000, "gate_hold");
    chk("gate_addr", bus.param_addr, 32'd0);
    chk("gate_busy", 32'(busy), 32'd0);
    params_ready = 1'b1;
    #1;
    chk("gate_ea_before", 32'(bus.param_ea), 32'd0);
    step(4'b0100, "gate_release");
    bus.req_valid = '0;
    #1;
    chk("gate_ea_after", 32'(bus.param_ea), 32'd1);
    chk("gate_addr_after", bus.param_addr, {word_v[2][29:0], 2'b00});
    drain("gate_drain");

    // Fairness: pointer sits at 3 after granting 2; requester 3 pulses, 1 stays on.
    word_v[1] = subset_word(10, PARAM_CX_OFFSET);
    word_v[3] = subset_word(11, PARAM_CY_OFFSET);
    bus.req_valid = 4'b0010;  step(4'b0010, "fair_a");
    bus.req_valid = 4'b1010;  step(4'b1000, "fair_b");
    bus.req_valid = 4'b0010;  step(4'b0010, "fair_c");
    bus.req_valid = 4'b0000;  step(4'b0000, "fair_idle0");
    step(4'b0000, "fair_idle1");
    bus.req_valid = 4'b1010;  step(4'b1000, "fair_d");
    step(4'b0010, "fair_e");
    step(4'b1000, "fair_f");
    bus.req_valid = '0;
    drain("fair_drain");

    // Reset while three reads are in flight; none of them may return.
    bus.req_valid = 4'b1111;
    step(4'b0001, "mid_g0");
    step(4'b0010, "mid_g1");
    step(4'b0100, "mid_g2");
    bus.req_valid = '0;
    do_reset();
    rsp_mark = rsp_count;
    for (int i = 0; i < 10; i++) @(negedge clock);
    chk("mid_no_rsp", 32'(rsp_count - rsp_mark), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);

    // Address wrap: top two index bits dropped.
    word_v[0]     = 32'hC000_0009;
    bus.req_valid = 4'b0001;
    step(4'b0001, "wrap_grant");
    bus.req_valid = '0;
    #1;
    chk("wrap_addr", bus.param_addr, 32'h0000_0024);
    drain("wrap_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
